// File: rtl/x86_prefix_fetch.sv
// x86_prefix_fetch: front-end prefix/escape/opcode fetch unit.
// Fetches one byte per cycle from a start IP. It absorbs legacy prefixes and
// the 0F escape, captures the opcode byte, and then presents a decoded record
// over a valid/ready handshake.
//
// Ports
//   clock, resetn          clock, synchronous active-low reset
//   locked                 global advance enable (0 freezes everything but reset)
//   start, ip_start, cs_d  decode request, first byte address, CS default size
//   address, rd            registered fetch address and byte read request
//   i_data, i_valid        fetched byte and its qualifier
//   dec_valid, dec_ready   record handshake
//   opcode .. fault        decoded record fields
//   busy                   unit is not idle
//
// state   | meaning
// S_IDLE  | waiting for start
// S_FETCH | reading and classifying bytes
// S_HOLD  | presenting the decoded record
module x86_prefix_fetch #(
    parameter int IPW    = 20,
    parameter int MAXLEN = 15
) (
    input  logic           clock,
    input  logic           resetn,
    input  logic           locked,
    input  logic           start,
    input  logic [IPW-1:0] ip_start,
    input  logic           cs_d,
    output logic [IPW-1:0] address,
    output logic           rd,
    input  logic [7:0]     i_data,
    input  logic           i_valid,
    output logic           dec_valid,
    input  logic           dec_ready,
    output logic [8:0]     opcode,
    output logic           opsize,
    output logic           adsize,
    output logic           lock,
    output logic [1:0]     rep,
    output logic           seg_of,
    output logic [2:0]     seg_id,
    output logic [3:0]     pfx_count,
    output logic [IPW-1:0] ip_next,
    output logic           fault,
    output logic           busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [IPW-1:0] IP_ONE    = {{(IPW-1){1'b0}}, 1'b1};
    localparam logic [4:0]     LEN_LIMIT = 5'(MAXLEN);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [IPW-1:0] r_ip;
    logic [3:0]     r_count;
    logic           r_esc;
    logic           r_cs_d;
    logic [8:0]     r_opcode;
    logic           r_opsize;
    logic           r_adsize;
    logic           r_lock;
    logic [1:0]     r_rep;
    logic           r_seg_of;
    logic [2:0]     r_seg_id;
    logic [3:0]     r_pfx_count;
    logic           r_fault;

    logic           w_accept;
    logic           w_start_go;
    logic           w_is_seg;
    logic           w_is_fsgs;
    logic           w_is_pfx;
    logic           w_is_esc;
    logic           w_limit;
    logic [4:0]     w_count_inc;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_start_go  = 1'b0;
        w_is_seg    = (i_data == 8'h26) || (i_data == 8'h2E) ||
                      (i_data == 8'h36) || (i_data == 8'h3E);
        w_is_fsgs   = (i_data == 8'h64) || (i_data == 8'h65);
        w_is_pfx    = w_is_seg || w_is_fsgs ||
                      (i_data == 8'h66) || (i_data == 8'h67) ||
                      (i_data == 8'hF0) || (i_data == 8'hF2) || (i_data == 8'hF3);
        w_is_esc    = (i_data == 8'h0F);
        w_count_inc = {1'b0, r_count} + 5'd1;
        // Once the escape is seen the next byte is always the opcode, so the
        // length limit only applies to prefix and 0F bytes.
        w_limit     = !r_esc && (w_is_pfx || w_is_esc) && (w_count_inc == LEN_LIMIT);

        case (r_state)
            S_IDLE: begin
                if (locked && start) begin
                    w_start_go  = 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                w_accept = i_valid && locked;
                if (w_accept && (r_esc || !(w_is_pfx || w_is_esc) || w_limit)) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (dec_ready && locked) begin
                    if (start) begin
                        w_start_go  = 1'b1;
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        rd        = (r_state == S_FETCH);
        dec_valid = (r_state == S_HOLD);
        busy      = (r_state != S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_ip        <= '0;
            r_count     <= '0;
            r_esc       <= 1'b0;
            r_cs_d      <= 1'b0;
            r_opcode    <= '0;
            r_opsize    <= 1'b0;
            r_adsize    <= 1'b0;
            r_lock      <= 1'b0;
            r_rep       <= '0;
            r_seg_of    <= 1'b0;
            r_seg_id    <= '0;
            r_pfx_count <= '0;
            r_fault     <= 1'b0;
        end else if (w_start_go) begin
            r_ip        <= ip_start;
            r_count     <= '0;
            r_esc       <= 1'b0;
            r_cs_d      <= cs_d;
            r_opcode    <= '0;
            r_opsize    <= cs_d;
            r_adsize    <= cs_d;
            r_lock      <= 1'b0;
            r_rep       <= '0;
            r_seg_of    <= 1'b0;
            r_seg_id    <= '0;
            r_pfx_count <= '0;
            r_fault     <= 1'b0;
        end else if (w_accept) begin
            r_ip    <= r_ip + IP_ONE;
            r_count <= w_count_inc[3:0];
            if (r_esc) begin
                r_opcode <= {1'b1, i_data};
            end else begin
                if (w_is_esc) begin
                    r_esc       <= 1'b1;
                    r_opcode[8] <= 1'b1;
                end
                if (w_is_seg) begin
                    r_seg_of <= 1'b1;
                    r_seg_id <= {1'b0, i_data[4:3]};
                end
                if (w_is_fsgs) begin
                    r_seg_of <= 1'b1;
                    r_seg_id <= {2'b10, i_data[0]};
                end
                // Size overrides flip relative to the CS default, so repeats are harmless.
                if (i_data == 8'h66) r_opsize <= ~r_cs_d;
                if (i_data == 8'h67) r_adsize <= ~r_cs_d;
                if (i_data == 8'hF0) r_lock   <= 1'b1;
                if ((i_data == 8'hF2) || (i_data == 8'hF3)) r_rep <= {1'b1, i_data[0]};
                if (w_is_pfx && (r_pfx_count != 4'hF)) r_pfx_count <= r_pfx_count + 4'd1;
                if (!w_is_pfx && !w_is_esc) r_opcode[7:0] <= i_data;
                if (w_limit) r_fault <= 1'b1;
            end
        end
    end

    assign address   = r_ip;
    assign ip_next   = r_ip;
    assign opcode    = r_opcode;
    assign opsize    = r_opsize;
    assign adsize    = r_adsize;
    assign lock      = r_lock;
    assign rep       = r_rep;
    assign seg_of    = r_seg_of;
    assign seg_id    = r_seg_id;
    assign pfx_count = r_pfx_count;
    assign fault     = r_fault;

endmodule
